packet_deframer: RTL and testbench
==================================

# packet_deframer

Byte-to-packet assembler that sits directly downstream of the host-side receive byte FIFO. It pops bytes through the FIFO's show-ahead read port, decodes the packet length from the opcode byte, and collects the full packet. It then presents the packet as one wide word, with a valid/ready handshake, to the core command decoder. Packets stalled mid-collection are dropped after a programmable timeout, and each drop is counted.

## Interface
- MAX_BYTES, 6: maximum packet length in bytes (fixed by the length code below).
- TIMEOUT, 1024: consecutive starved cycles in COLLECT before the partial packet is dropped; must be ≥1.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- fifo_rd_data  in  8  head byte of upstream FIFO; valid whenever fifo_empty is low (show-ahead).
- fifo_empty  in  1  upstream FIFO empty.
- fifo_rd_en  out  1  pop strobe; byte on fifo_rd_data is consumed in this cycle.
- pkt_data  out  8*MAX_BYTES  assembled packet; byte i at [8i+7:8i]; byte 0 is the opcode; unused bytes are zero.
- pkt_len  out  3  packet length in bytes (1, 2, 4 or 6).
- pkt_valid  out  1  packet available.
- pkt_ready  in  1  downstream accepts packet.
- timeout_err  out  1  one-cycle pulse when a partial packet is dropped.
- drop_count  out  8  number of dropped packets; saturates at 255.

## Operation
- Length code is opcode[7:6]: 00→1 byte, 01→2, 10→4, 11→6.
- fifo_rd_en = !fifo_empty && (state==IDLE || state==COLLECT). It is combinational and never asserted while fifo_empty is high.
- IDLE:
  - On a pop, store the byte as byte 0, clear bytes 1..5 and latch pkt_len.
  - If the length is 1, go to EMIT; otherwise set idx=1 and go to COLLECT.
- COLLECT:
  - On a pop, store the byte at index idx and increment idx. Reset the starve counter.
  - If idx+1==pkt_len, go to EMIT.
  - On a cycle with no pop, increment the starve counter.
  - When the starve counter reaches TIMEOUT-1 in a starved cycle: go to IDLE, pulse timeout_err, increment drop_count (saturating at 255), clear the starve counter, and discard the collected bytes.
- EMIT:
  - pkt_valid is high, and pkt_data and pkt_len are held stable.
  - On pkt_valid && pkt_ready, go to IDLE.
  - No pop occurs in EMIT, including the handshake cycle.
- The starve counter only runs in COLLECT and is cleared on entry to COLLECT.

## Timing
- Reset values: state=IDLE, pkt_valid=0, pkt_data=0, pkt_len=0, timeout_err=0, drop_count=0, starve counter=0, fifo_rd_en=0 at the reset edge.
- Reset asserted mid-packet discards the partial packet with no timeout_err and no drop_count increment.
- With bytes continuously available, a k-byte packet is popped on cycles N..N+k-1 and pkt_valid rises on N+k.
- With pkt_ready high, pkt_valid stays high for exactly one cycle. The next opcode pop occurs at the earliest on the cycle after the handshake, giving k+1 cycles per packet.
- pkt_ready held low: pkt_valid, pkt_data and pkt_len are held indefinitely, and no bytes are popped.
- Timeout: the drop occurs after exactly TIMEOUT consecutive starved cycles in COLLECT.
  - timeout_err is high on the cycle after the TIMEOUT-th starved cycle, when the state is already IDLE.
  - A byte arriving on the TIMEOUT-th starved cycle is a pop, so no drop occurs.
- A byte popped in IDLE after a timeout is treated as a new opcode; resynchronisation is the host's responsibility.

## Test plan
- Reset, then push 0x05 → one pop; pkt_valid one cycle later; pkt_len=1, pkt_data=0x000000000005; remains valid until pkt_ready.
- Push 0xC1,0x11,0x22,0x33,0x44,0x55 back-to-back with pkt_ready=1 → six pops on consecutive cycles; pkt_len=6, pkt_data=0x5544332211C1, valid for one cycle.
- Push 0x80,0xAA,0xBB,0xCC then 0x41,0xDD with pkt_ready low for 10 cycles:
  - first packet 0xCCBBAA80 is held for all 10 cycles, with no pops;
  - after the handshake, the second packet has pkt_len=2 and pkt_data=0xDD41.
- TIMEOUT=16; push 0x80,0x01 then starve:
  - timeout_err pulses once after 16 starved cycles and drop_count becomes 1;
  - a subsequent push of 0x02 yields a 1-byte packet 0x02.
- Repeat the timeout 256 times → drop_count saturates at 255.
- Assert reset after the 3rd byte of a 6-byte packet → outputs return to reset values; drop_count is unchanged at 0; a following 0x00 yields a 1-byte packet.

Source files
------------

// File: rtl/packet_deframer.sv
`default_nettype none
// ============================================================================
// Module   : packet_deframer
// Purpose  : Pops bytes from a show-ahead receive FIFO, decodes the packet
//            length from the opcode byte, assembles the packet and presents
//            it as one wide word with a valid/ready handshake. Partial
//            packets that starve for TIMEOUT cycles are dropped and counted.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            fifo_rd_data       - head byte of upstream FIFO (show-ahead)
//            fifo_empty         - upstream FIFO empty
//            fifo_rd_en         - pop strobe (combinational)
//            pkt_data           - assembled packet, byte 0 = opcode
//            pkt_len            - packet length in bytes (1, 2, 4 or 6)
//            pkt_valid          - packet available
//            pkt_ready          - downstream accepts packet
//            timeout_err        - one-cycle pulse on a dropped packet
//            drop_count         - saturating count of dropped packets
// Revision : 1.0 - initial release
// ============================================================================
module packet_deframer #(
  parameter int MAX_BYTES = 6,
  parameter int TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             fifo_rd_data,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic [8*MAX_BYTES-1:0] pkt_data,
  output logic [2:0]             pkt_len,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic                   timeout_err,
  output logic [7:0]             drop_count
);

  localparam int                  STARVE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t              state;
  logic [2:0]          idx;
  logic [STARVE_W-1:0] starve;

  // Length code lives in the two top bits of the opcode.
  function automatic logic [2:0] decode_len(input logic [7:0] opcode);
    case (opcode[7:6])
      2'b00:   decode_len = 3'd1;
      2'b01:   decode_len = 3'd2;
      2'b10:   decode_len = 3'd4;
      default: decode_len = 3'd6;
    endcase
  endfunction

  // Popping is held off during reset so no byte is lost at the reset edge.
  assign fifo_rd_en = !reset && !fifo_empty && (state == IDLE || state == COLLECT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 3'd0;
      starve      <= '0;
      pkt_data    <= '0;
      pkt_len     <= 3'd0;
      pkt_valid   <= 1'b0;
      timeout_err <= 1'b0;
      drop_count  <= 8'd0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_rd_en) begin
            pkt_data <= {{(8*MAX_BYTES-8){1'b0}}, fifo_rd_data};
            pkt_len  <= decode_len(fifo_rd_data);
            if (decode_len(fifo_rd_data) == 3'd1) begin
              pkt_valid <= 1'b1;
              state     <= EMIT;
            end else begin
              idx    <= 3'd1;
              starve <= '0;
              state  <= COLLECT;
            end
          end
        end

        COLLECT: begin
          if (fifo_rd_en) begin
            pkt_data[8*int'(idx) +: 8] <= fifo_rd_data;
            idx                        <= idx + 3'd1;
            starve                     <= '0;
            if (idx + 3'd1 == pkt_len) begin
              pkt_valid <= 1'b1;
              state     <= EMIT;
            end
          end else if (starve == STARVE_LAST) begin
            // TIMEOUT-th consecutive starved cycle: drop the partial packet.
            state       <= IDLE;
            timeout_err <= 1'b1;
            starve      <= '0;
            pkt_data    <= '0;
            pkt_len     <= 3'd0;
            if (drop_count != 8'hFF) begin
              drop_count <= drop_count + 8'd1;
            end
          end else begin
            starve <= starve + 1'b1;
          end
        end

        EMIT: begin
          if (pkt_ready) begin
            pkt_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          pkt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_deframer
// Purpose  : Directed self-checking bench for packet_deframer (TIMEOUT=16).
//            A simple show-ahead FIFO model feeds the DUT; each task drives
//            one scenario and compares outputs against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_deframer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [47:0] pkt_data;
  logic [2:0]  pkt_len;
  logic        pkt_valid;
  logic        pkt_ready = 1'b0;
  logic        timeout_err;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  // Show-ahead FIFO model: tasks push at the tail, the DUT pops the head.
  logic [7:0] mem [0:2047];
  int head = 0;
  int tail = 0;

  assign fifo_empty   = (head == tail);
  assign fifo_rd_data = mem[head];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      checks++;
      if (fifo_empty) begin
        errors++;
        $display("FAIL pop_when_empty: fifo_rd_en=1 with fifo_empty=1");
      end
      head <= head + 1;
    end
  end

  packet_deframer #(.MAX_BYTES(6), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .pkt_data(pkt_data), .pkt_len(pkt_len), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .timeout_err(timeout_err), .drop_count(drop_count)
  );

  task automatic push(input logic [7:0] b);
    mem[tail] = b;
    tail = tail + 1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pkt_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pkt_valid); end
    checks++; if (pkt_data !== 48'h0) begin errors++; $display("FAIL reset_data: got %h want 0", pkt_data); end
    checks++; if (pkt_len !== 3'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", pkt_len); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b want 0", fifo_rd_en); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    pkt_ready = 1'b0;
    push(8'h05);
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL single_rden: got %b want 1", fifo_rd_en); end
    @(negedge clk);
    checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", pkt_valid); end
    checks++; if (pkt_len !== 3'd1) begin errors++; $display("FAIL single_len: got %0d want 1", pkt_len); end
    checks++; if (pkt_data !== 48'h000000000005) begin errors++; $display("FAIL single_data: got %h want 000000000005", pkt_data); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL single_emit_rden: got %b want 0", fifo_rd_en); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL single_hold_valid: cycle %0d got %b want 1", i, pkt_valid); end
    end
    pkt_ready = 1'b1;
    @(negedge clk);
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL single_release: got %b want 0", pkt_valid); end
    pkt_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    pkt_ready = 1'b1;
    push(8'hC1); push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL b2b_pop: byte %0d rd_en got %b want 1", i, fifo_rd_en); end
      checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid: byte %0d got %b want 0", i, pkt_valid); end
      @(negedge clk);
    end
    checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", pkt_valid); end
    checks++; if (pkt_len !== 3'd6) begin errors++; $display("FAIL b2b_len: got %0d want 6", pkt_len); end
    checks++; if (pkt_data !== 48'h5544332211C1) begin errors++; $display("FAIL b2b_data: got %h want 5544332211c1", pkt_data); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL b2b_emit_rden: got %b want 0", fifo_rd_en); end
    @(negedge clk);
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL b2b_one_cycle: got %b want 0", pkt_valid); end
    pkt_ready = 1'b0;
  endtask

  task automatic test_hold;
    pkt_ready = 1'b0;
    push(8'h80); push(8'hAA); push(8'hBB); push(8'hCC); push(8'h41); push(8'hDD);
    repeat (4) @(negedge clk);
    checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b want 1", pkt_valid); end
    checks++; if (pkt_len !== 3'd4) begin errors++; $display("FAIL hold_len: got %0d want 4", pkt_len); end
    checks++; if (pkt_data !== 48'h0000CCBBAA80) begin errors++; $display("FAIL hold_data: got %h want 0000ccbbaa80", pkt_data); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (pkt_valid !== 1'b1 || pkt_data !== 48'h0000CCBBAA80 || pkt_len !== 3'd4 ||
          fifo_rd_en !== 1'b0 || head !== tail - 2) begin
        errors++;
        $display("FAIL hold_stall: cycle %0d valid=%b data=%h len=%0d rd_en=%b left=%0d want 1/0000ccbbaa80/4/0/2",
                 i, pkt_valid, pkt_data, pkt_len, fifo_rd_en, tail - head);
      end
    end
    pkt_ready = 1'b1;
    @(negedge clk);
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", pkt_valid); end
    repeat (2) @(negedge clk);
    checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL hold_second_valid: got %b want 1", pkt_valid); end
    checks++; if (pkt_len !== 3'd2) begin errors++; $display("FAIL hold_second_len: got %0d want 2", pkt_len); end
    checks++; if (pkt_data !== 48'h00000000DD41) begin errors++; $display("FAIL hold_second_data: got %h want 00000000dd41", pkt_data); end
    @(negedge clk);
    pkt_ready = 1'b0;
  endtask

  task automatic test_reset_mid_packet;
    pkt_ready = 1'b0;
    push(8'hC0); push(8'h01); push(8'h02);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (pkt_valid !== 1'b0 || pkt_data !== 48'h0 || pkt_len !== 3'd0 || timeout_err !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL midrst_outputs: valid=%b data=%h len=%0d terr=%b drop=%0d want all zero",
               pkt_valid, pkt_data, pkt_len, timeout_err, drop_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL midrst_terr: cycle %0d got %b want 0", i, timeout_err); end
    end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL midrst_drop: got %0d want 0", drop_count); end
    push(8'h00);
    @(negedge clk);
    checks++; if (pkt_valid !== 1'b1 || pkt_len !== 3'd1 || pkt_data !== 48'h0) begin
      errors++;
      $display("FAIL midrst_next_pkt: valid=%b len=%0d data=%h want 1/1/000000000000", pkt_valid, pkt_len, pkt_data);
    end
    pkt_ready = 1'b1;
    @(negedge clk);
    pkt_ready = 1'b0;
  endtask

  // A byte arriving on the 16th starved cycle is a pop, not a drop.
  task automatic test_timeout_boundary;
    pkt_ready = 1'b0;
    push(8'h80); push(8'h01);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tob_terr: cycle %0d got %b want 0", i, timeout_err); end
    end
    push(8'hAB); push(8'hCD);
    repeat (2) @(negedge clk);
    checks++; if (pkt_valid !== 1'b1 || pkt_len !== 3'd4 || pkt_data !== 48'h0000CDAB0180) begin
      errors++;
      $display("FAIL tob_pkt: valid=%b len=%0d data=%h want 1/4/0000cdab0180", pkt_valid, pkt_len, pkt_data);
    end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL tob_drop: got %0d want 0", drop_count); end
    pkt_ready = 1'b1;
    @(negedge clk);
    pkt_ready = 1'b0;
  endtask

  task automatic test_timeout;
    pkt_ready = 1'b0;
    push(8'h80); push(8'h01);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++; if (timeout_err !== 1'b0 || pkt_valid !== 1'b0) begin
        errors++; $display("FAIL to_early: cycle %0d terr=%b valid=%b want 0/0", i, timeout_err, pkt_valid);
      end
    end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", timeout_err); end
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL to_drop: got %0d want 1", drop_count); end
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL to_valid: got %b want 0", pkt_valid); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_one_cycle: got %b want 0", timeout_err); end
    push(8'h02);
    @(negedge clk);
    checks++; if (pkt_valid !== 1'b1 || pkt_len !== 3'd1 || pkt_data !== 48'h000000000002) begin
      errors++;
      $display("FAIL to_resync: valid=%b len=%0d data=%h want 1/1/000000000002", pkt_valid, pkt_len, pkt_data);
    end
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL to_drop_stable: got %0d want 1", drop_count); end
    pkt_ready = 1'b1;
    @(negedge clk);
    pkt_ready = 1'b0;
  endtask

  task automatic test_saturation;
    int exp_drop;
    pkt_ready = 1'b0;
    for (int n = 2; n <= 257; n++) begin
      exp_drop = (n > 255) ? 255 : n;
      push(8'h40);
      @(negedge clk);
      repeat (16) @(negedge clk);
      checks++; if (timeout_err !== 1'b1 || drop_count !== exp_drop[7:0]) begin
        errors++;
        $display("FAIL sat_drop: drop %0d terr=%b count=%0d want 1/%0d", n, timeout_err, drop_count, exp_drop);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_reset_mid_packet();
    test_timeout_boundary();
    test_timeout();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
